spi_cmd_decoder: RTL
====================

Name: spi_cmd_decoder

Overview:
- Sits between `spi_slave` (byte stream on the 300 MHz domain) and the waveform block RAM and the `ad9744_module` enable.
- Assembles 4-byte SPI frames, MSB first, into 32-bit command words and decodes them.
- Drives the RAM write port, tracks the loaded sample count and controls function-generator run/stop.
- All logic is synchronous to `i_Clk`; it replaces the byte-strobe-clocked assembly logic.

Parameters:
- ADDR_SIZE, 8, RAM address width; legal range 1..13.
- DATA_WIDTH, 14, DAC sample width; fixed to 14 in this revision.

Ports:
- i_Clk  input  1  system clock (clk_300MHz); all logic on rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_RX_DV  input  1  one-cycle byte-valid pulse from `spi_slave`.
- i_RX_Byte  input  8  received byte; valid when i_RX_DV=1.
- i_SPI_CS_n  input  1  raw SPI chip select, active low, asynchronous to i_Clk.
- o_Mem_WE  output  1  RAM write enable, one-cycle pulse.
- o_Mem_Addr  output  ADDR_SIZE  RAM write address.
- o_Mem_Data  output  DATA_WIDTH  RAM write data.
- o_Samples  output  ADDR_SIZE+1  number of loaded samples (highest written address + 1).
- o_Fgen_En  output  1  playback enable to `ad9744_module`.
- o_Frame_Err  output  1  one-cycle pulse on any rejected or aborted frame.
- o_LED  output  8  status code.

Behaviour:
- Reset, while i_Rst_L=0, asynchronous:
  - o_Mem_WE=0, o_Mem_Addr=0, o_Mem_Data=0, o_Samples=0, o_Fgen_En=0, o_Frame_Err=0, o_LED=0.
  - byte_cnt=0, state=COLLECT, CS synchronizer flops=1.
  - Asserting reset mid-frame discards the partial word.
- CS handling:
  - i_SPI_CS_n passes through a 2-flop synchronizer.
  - cs_rise is asserted when the synchronized value goes 0->1.
- State COLLECT:
  - Each i_RX_DV shifts i_RX_Byte into word[31:0] MSB first and increments byte_cnt.
  - When the 4th byte arrives (byte_cnt==3 with i_RX_DV): byte_cnt returns to 0 and state moves to EXEC on the next edge.
- Abort on CS:
  - cs_rise with byte_cnt!=0 discards the partial word, sets byte_cnt=0 and pulses o_Frame_Err.
  - cs_rise in the same cycle as i_RX_DV takes priority: the byte is dropped.
  - cs_rise with byte_cnt==0 has no effect.
- State EXEC (exactly one cycle, then back to COLLECT). The opcode is word[31:28]:
  - 1 WRITE:
    - Active only if o_Fgen_En=0.
    - o_Mem_WE=1 for this one cycle.
    - o_Mem_Addr=word[14+ADDR_SIZE-1:14]; o_Mem_Data=word[13:0].
    - If addr+1 > o_Samples, then o_Samples<=addr+1.
    - o_LED<=1.
    - If o_Fgen_En=1: no write, o_Frame_Err pulse.
  - 2 RUN:
    - If o_Samples!=0: o_Fgen_En<=1, o_LED<=2.
    - Otherwise: o_Frame_Err pulse, no change.
  - 3 STOP: o_Fgen_En<=0, o_LED<=4.
  - 4 CLEAR:
    - Only if o_Fgen_En=0: o_Samples<=0, o_LED<=8.
    - If running: o_Frame_Err pulse.
  - Any other opcode: o_Frame_Err pulse, no other effect.
- Bytes arriving during EXEC are accepted into the next frame. The spi_slave byte period is far longer than one cycle, so no byte is lost.
- Latency:
  - 4th-byte i_RX_DV at edge N gives o_Mem_WE/o_Fgen_En/o_LED updated at edge N+1.
  - o_Mem_WE deasserts at edge N+2.
- o_Mem_Addr and o_Mem_Data hold their last written values when not writing.
- o_Frame_Err is high for exactly one cycle per event.
- Wrap: address field bits above ADDR_SIZE are ignored. o_Samples saturates naturally at 2^ADDR_SIZE because addr+1 ≤ 2^ADDR_SIZE.

Test Plan:
- Frame 0x10_00_41_23 (WRITE addr=1, data=0x0123) → one-cycle o_Mem_WE, o_Mem_Addr=1, o_Mem_Data=0x0123, o_Samples=2, o_LED=1; WE asserted on the edge after the 4th i_RX_DV.
- Send RUN (0x20000000) with o_Samples=0 → o_Frame_Err single pulse, o_Fgen_En stays 0. Then WRITE addr=0 followed by RUN → o_Samples=1, o_Fgen_En=1, o_LED=2.
- While running, send WRITE addr=5 and CLEAR (0x40000000) → no o_Mem_WE, two o_Frame_Err pulses, o_Samples unchanged. STOP (0x30000000) → o_Fgen_En=0, o_LED=4.
- Send 2 bytes, then raise CS, then send a full WRITE frame addr=3 data=0x3FFF → o_Frame_Err pulse at abort; the following frame decodes correctly (addr=3, data=0x3FFF).
- Assert i_Rst_L=0 after 3 bytes of a frame, release, then send WRITE addr=7 → all outputs 0 during reset; the post-reset frame decodes with addr=7 and no stale bytes.
- WRITE addr=255 (ADDR_SIZE=8) → o_Samples=256; opcode 0xF → o_Frame_Err pulse only.

Source files
------------

// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: byte stream in from spi_slave, RAM write port and playback control out.
interface spi_cmd_decoder_if #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 14
);
  logic                  i_RX_DV;
  logic [7:0]            i_RX_Byte;
  logic                  i_SPI_CS_n;
  logic                  o_Mem_WE;
  logic [ADDR_SIZE-1:0]  o_Mem_Addr;
  logic [DATA_WIDTH-1:0] o_Mem_Data;
  logic [ADDR_SIZE:0]    o_Samples;
  logic                  o_Fgen_En;
  logic                  o_Frame_Err;
  logic [7:0]            o_LED;
  modport slave (
    input  i_RX_DV, i_RX_Byte, i_SPI_CS_n,
    output o_Mem_WE, o_Mem_Addr, o_Mem_Data, o_Samples, o_Fgen_En, o_Frame_Err, o_LED
  );
  modport master (
    output i_RX_DV, i_RX_Byte, i_SPI_CS_n,
    input  o_Mem_WE, o_Mem_Addr, o_Mem_Data, o_Samples, o_Fgen_En, o_Frame_Err, o_LED
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: assembles 4-byte MSB-first SPI frames into command words and executes them.
module spi_cmd_decoder #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 14
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  spi_cmd_decoder_if.slave bus
);
  typedef enum logic {COLLECT, EXEC} state_t;
  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic                  cs_meta_q, cs_sync_q, cs_prev_q;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ADDR_SIZE:0]    samples_q, samples_d;
  logic                  fgen_en_q, fgen_en_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            led_q, led_d;
  logic                  cs_rise, take, is_exec, wr_ok, run_ok, stop_ok, clr_ok, bad;
  logic [3:0]            op;
  logic [ADDR_SIZE-1:0]  addr;
  logic [ADDR_SIZE:0]    addr_inc;
  logic                  unused_bits;
  assign unused_bits = ^word_q[27:14+ADDR_SIZE];
  always_comb begin
    cs_rise     = cs_sync_q & ~cs_prev_q;
    take        = bus.i_RX_DV & ~cs_rise;
    byte_cnt_d  = cs_rise ? 2'd0 : take ? byte_cnt_q + 2'd1 : byte_cnt_q;
    word_d      = take ? {word_q[23:0], bus.i_RX_Byte} : word_q;
    state_d     = (take && byte_cnt_q == 2'd3) ? EXEC : COLLECT;
    is_exec     = state_q == EXEC;
    op          = word_q[31:28];
    addr        = word_q[14+ADDR_SIZE-1:14];
    addr_inc    = {1'b0, addr} + 1'b1;
    wr_ok       = is_exec && op == 4'd1 && !fgen_en_q;
    run_ok      = is_exec && op == 4'd2 && samples_q != '0;
    stop_ok     = is_exec && op == 4'd3;
    clr_ok      = is_exec && op == 4'd4 && !fgen_en_q;
    bad         = is_exec && !(wr_ok || run_ok || stop_ok || clr_ok);
    mem_we_d    = wr_ok;
    mem_addr_d  = wr_ok ? addr : mem_addr_q;
    mem_data_d  = wr_ok ? word_q[DATA_WIDTH-1:0] : mem_data_q;
    samples_d   = clr_ok ? '0 : (wr_ok && addr_inc > samples_q) ? addr_inc : samples_q;
    fgen_en_d   = run_ok ? 1'b1 : stop_ok ? 1'b0 : fgen_en_q;
    led_d       = wr_ok ? 8'd1 : run_ok ? 8'd2 : stop_ok ? 8'd4 : clr_ok ? 8'd8 : led_q;
    // an abort only matters once part of a frame has been collected
    frame_err_d = bad || (cs_rise && byte_cnt_q != 2'd0);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      samples_q   <= '0;
      fgen_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      cs_meta_q   <= bus.i_SPI_CS_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      samples_q   <= samples_d;
      fgen_en_q   <= fgen_en_d;
      frame_err_q <= frame_err_d;
      led_q       <= led_d;
    end
  end
  assign bus.o_Mem_WE    = mem_we_q;
  assign bus.o_Mem_Addr  = mem_addr_q;
  assign bus.o_Mem_Data  = mem_data_q;
  assign bus.o_Samples   = samples_q;
  assign bus.o_Fgen_En   = fgen_en_q;
  assign bus.o_Frame_Err = frame_err_q;
  assign bus.o_LED       = led_q;
endmodule
